// File: rtl/rshift_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rshift_share_arbiter_if
// Description : Request and result bundle of the shared rescale-shifter
//               arbiter. Request side carries per-head valid/ready/data;
//               result side carries the buffered, tagged shifter output
//               and the occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
interface rshift_share_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int VEC_W      = 512,
    parameter int ID_W       = 2,
    parameter int FIFO_DEPTH = 4
) ();
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*VEC_W-1:0] req_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [VEC_W-1:0]         out_data;
    logic [ID_W-1:0]          out_id;
    logic [CNT_W-1:0]         inflight;

    // Producer/consumer side (score heads and softmax stage)
    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id, inflight
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id, inflight
    );
endinterface
`default_nettype wire

// File: rtl/rshift_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rshift_share_arbiter
// Description : Round-robin arbiter that time-shares one fixed-latency
//               arithmetic-right-shift datapath among NUM_REQ heads. Tracks
//               in-flight tags alongside the shifter, buffers results in a
//               first-word-fall-through FIFO and throttles issue by credit so
//               the FIFO can never overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module rshift_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int VEC_W      = 512,
    parameter int PIPE_LAT   = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = 2
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    rshift_share_arbiter_if.slave  bus,
    output logic [VEC_W-1:0]       sh_data,
    input  wire logic [VEC_W-1:0]  sh_result
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Arbitration state
    logic [ID_W-1:0]     last_grant;
    logic [ID_W-1:0]     grant_id;
    logic                grant_found;
    logic                credit_ok;
    logic                issue;

    // Tag pipeline that shadows the shifter latency
    logic [PIPE_LAT-1:0] tag_valid;
    logic [ID_W-1:0]     tag_id [PIPE_LAT];

    // Occupancy
    logic [CNT_W-1:0]    pipe_count;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W-1:0]    total_count;

    // Output buffer
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [VEC_W-1:0]    fifo_data [FIFO_DEPTH];
    logic [ID_W-1:0]     fifo_id   [FIFO_DEPTH];
    logic                push;
    logic                pop;

    // Credit is taken from registered counts only, so a pop frees its
    // slot one cycle later and there is no ready->valid combinational loop.
    assign total_count = pipe_count + fifo_count;
    assign credit_ok   = total_count < CNT_W'(FIFO_DEPTH);
    assign issue       = rst_n && credit_ok && grant_found;
    assign push        = tag_valid[PIPE_LAT-1];
    assign pop         = (fifo_count != '0) && bus.out_ready;

    // Pick the first valid head at or after last_grant+1, wrapping
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(last_grant) + 1 + i) % NUM_REQ;
            if (!grant_found && bus.req_valid[ID_W'(idx)]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    // One-hot accept for the granted head; held low during reset so no
    // producer believes a beat was taken that reset is about to drop
    always_comb begin
        bus.req_ready = '0;
        if (issue) begin
            bus.req_ready[grant_id] = 1'b1;
        end
    end

    // Steer the granted vector to the shifter, zero when nothing issues
    always_comb begin
        sh_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (issue && (grant_id == ID_W'(i))) begin
                sh_data = bus.req_data[i*VEC_W +: VEC_W];
            end
        end
    end

    // Round-robin pointer advances only on a completed handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (issue) begin
            last_grant <= grant_id;
        end
    end

    // Tag shift register aligned with the shifter data latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_valid <= '0;
            for (int s = 0; s < PIPE_LAT; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_valid[0] <= issue;
            tag_id[0]    <= grant_id;
            for (int s = 1; s < PIPE_LAT; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_id[s]    <= tag_id[s-1];
            end
        end
    end

    // Beats inside the shifter: +1 on issue, -1 on return, both may coincide
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_count <= '0;
        end else begin
            case ({issue, push})
                2'b10:   pipe_count <= pipe_count + CNT_W'(1);
                2'b01:   pipe_count <= pipe_count - CNT_W'(1);
                default: pipe_count <= pipe_count;
            endcase
        end
    end

    // FIFO pointers and fill level; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage; stale entries are never visible because the output is
    // masked by the reset-cleared fill level
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= sh_result;
            fifo_id[wr_ptr]   <= tag_id[PIPE_LAT-1];
        end
    end

    // First-word-fall-through head, forced to zero when empty
    always_comb begin
        bus.out_valid = (fifo_count != '0);
        bus.out_data  = '0;
        bus.out_id    = '0;
        if (bus.out_valid) begin
            bus.out_data = fifo_data[rd_ptr];
            bus.out_id   = fifo_id[rd_ptr];
        end
        bus.inflight  = total_count;
    end
endmodule
`default_nettype wire

// File: tb/tb_rshift_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rshift_share_arbiter
// Description : Directed self-checking bench for rshift_share_arbiter with a
//               behavioural one-cycle >>>4 shifter on 16-bit elements.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rshift_share_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int VEC_W      = 512;
    localparam int PIPE_LAT   = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int ID_W       = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [VEC_W-1:0] sh_data;
    logic [VEC_W-1:0] sh_result;
    int               checks = 0;
    int               failures = 0;

    rshift_share_arbiter_if #(.NUM_REQ(NUM_REQ), .VEC_W(VEC_W), .ID_W(ID_W),
                              .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    rshift_share_arbiter #(
        .NUM_REQ(NUM_REQ), .VEC_W(VEC_W), .PIPE_LAT(PIPE_LAT),
        .FIFO_DEPTH(FIFO_DEPTH), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .sh_data(sh_data), .sh_result(sh_result)
    );

    always #5 clk = ~clk;

    function automatic logic [VEC_W-1:0] shift_model(input logic [VEC_W-1:0] v);
        logic [VEC_W-1:0]   r;
        logic signed [15:0] e;
        r = '0;
        for (int i = 0; i < VEC_W/16; i++) begin
            e = v[i*16 +: 16];
            r[i*16 +: 16] = e >>> 4;
        end
        return r;
    endfunction

    // Shared shifter model with one cycle of latency
    always @(posedge clk) sh_result <= shift_model(sh_data);

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // Head h, beat k: element0 = h*0x100 + k*0x10 (shifts to h*0x10+k),
    // element1 = 0x8000|k (shifts to 0xF800)
    task automatic set_all(input int k);
        bus.req_data = '0;
        for (int h = 0; h < NUM_REQ; h++) begin
            bus.req_data[h*VEC_W +: 16]      = 16'(h*256 + k*16);
            bus.req_data[h*VEC_W + 16 +: 16] = 16'h8000 | 16'(k);
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.out_ready = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; bus.req_valid = '1; bus.out_ready = 1'b1; set_all(0);
        cyc(); cyc(); #1;
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== '0) begin failures++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data[31:0]); end
        checks++; if (bus.out_id !== 2'd0) begin failures++; $display("FAIL reset_out_id: got %0d expected 0", bus.out_id); end
        checks++; if (bus.inflight !== 3'd0) begin failures++; $display("FAIL reset_inflight: got %0d expected 0", bus.inflight); end
        rst_n = 1'b1; bus.req_valid = '0;
        cyc();
    endtask

    task automatic test_single;
        bus.req_data = '0;
        bus.req_data[2*VEC_W +: 32] = 32'h0130_FFF0;
        bus.req_valid = 4'b0100; bus.out_ready = 1'b1; #1;
        checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL single_grant: got %b expected 0100", bus.req_ready); end
        checks++; if (sh_data[31:0] !== 32'h0130_FFF0) begin failures++; $display("FAIL single_sh_data: got %h expected 0130fff0", sh_data[31:0]); end
        cyc(); bus.req_valid = '0; #1;
        checks++; if (bus.inflight !== 3'd1) begin failures++; $display("FAIL single_inflight_c1: got %0d expected 1", bus.inflight); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid: got %b expected 0", bus.out_valid); end
        checks++; if (sh_data !== '0) begin failures++; $display("FAIL single_sh_idle: got %h expected 0", sh_data[31:0]); end
        cyc();
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL single_valid_c2: got %b expected 1", bus.out_valid); end
        checks++; if (bus.out_id !== 2'd2) begin failures++; $display("FAIL single_id: got %0d expected 2", bus.out_id); end
        checks++; if (bus.out_data[31:0] !== 32'h0013_FFFF) begin failures++; $display("FAIL single_data: got %h expected 0013ffff", bus.out_data[31:0]); end
        checks++; if (bus.inflight !== 3'd1) begin failures++; $display("FAIL single_inflight_c2: got %0d expected 1", bus.inflight); end
        cyc();
        checks++; if (bus.inflight !== 3'd0) begin failures++; $display("FAIL single_inflight_c3: got %0d expected 0", bus.inflight); end
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin failures++; $display("FAIL single_drained: got valid=%b data=%h expected 0/0", bus.out_valid, bus.out_data[31:0]); end
    endtask

    task automatic test_rr;
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin bus.req_valid = '1; set_all(k); end
            else bus.req_valid = '0;
            #1;
            if (k < 8) begin
                checks++; if (bus.req_ready !== 4'(1 << (k % 4))) begin failures++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, bus.req_ready, 4'(1 << (k % 4))); end
            end
            if (k >= 2) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== ID_W'((k-2) % 4)) begin failures++; $display("FAIL rr_out[%0d]: got valid=%b id=%0d expected 1/%0d", k-2, bus.out_valid, bus.out_id, (k-2) % 4); end
                checks++; if (bus.out_data[15:0] !== 16'(((k-2) % 4)*16 + (k-2))) begin failures++; $display("FAIL rr_data[%0d]: got %h expected %h", k-2, bus.out_data[15:0], 16'(((k-2) % 4)*16 + (k-2))); end
            end
            if (k >= 2 && k <= 8) begin
                checks++; if (bus.inflight !== 3'd2) begin failures++; $display("FAIL rr_inflight[%0d]: got %0d expected 2", k, bus.inflight); end
            end
            cyc();
        end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rr_end_valid: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 18; k++) begin
            if (k < 16) begin bus.req_valid = '1; set_all(k); end
            else bus.req_valid = '0;
            #1;
            if (k >= 2) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== ID_W'((k-2) % 4)) begin failures++; $display("FAIL b2b_out[%0d]: got valid=%b id=%0d expected 1/%0d", k-2, bus.out_valid, bus.out_id, (k-2) % 4); end
                checks++; if (bus.out_data[31:0] !== {16'hF800, 16'(((k-2) % 4)*16 + (k-2))}) begin failures++; $display("FAIL b2b_data[%0d]: got %h expected %h", k-2, bus.out_data[31:0], {16'hF800, 16'(((k-2) % 4)*16 + (k-2))}); end
            end
            if (k >= 2 && k <= 16) begin
                checks++; if (bus.inflight !== 3'd2) begin failures++; $display("FAIL b2b_inflight[%0d]: got %0d expected 2", k, bus.inflight); end
            end
            cyc();
        end
    endtask

    task automatic test_sparse;
        logic [3:0]      eg  [5];
        logic [ID_W-1:0] eid [5];
        eg  = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010};
        eid = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1};
        do_reset();
        bus.out_ready = 1'b1;
        for (int t = 0; t < 7; t++) begin
            bus.req_valid = (t == 0) ? 4'b0010 : (t <= 4) ? 4'b1010 : 4'b0000;
            set_all(t);
            #1;
            if (t <= 4) begin
                checks++; if (bus.req_ready !== eg[t]) begin failures++; $display("FAIL sparse_grant[%0d]: got %b expected %b", t, bus.req_ready, eg[t]); end
            end
            if (t >= 2) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== eid[t-2] || bus.out_data[15:0] !== 16'(int'(eid[t-2])*16 + t - 2)) begin failures++; $display("FAIL sparse_out[%0d]: got valid=%b id=%0d d=%h expected id=%0d", t-2, bus.out_valid, bus.out_id, bus.out_data[15:0], eid[t-2]); end
            end
            cyc();
        end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL sparse_end_valid: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_backpressure;
        logic [ID_W-1:0] ids [4];
        ids = '{2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        bus.out_ready = 1'b0; bus.req_valid = '1; set_all(0);
        for (int t = 0; t < 6; t++) begin
            #1;
            checks++; if (bus.req_ready !== ((t < 4) ? 4'(1 << t) : 4'b0000)) begin failures++; $display("FAIL bp_grant[%0d]: got %b expected %b", t, bus.req_ready, (t < 4) ? 4'(1 << t) : 4'b0000); end
            cyc();
        end
        checks++; if (bus.inflight !== 3'd4) begin failures++; $display("FAIL bp_full: got %0d expected 4", bus.inflight); end
        bus.out_ready = 1'b1; #1;
        checks++; if (bus.req_ready !== 4'b0000 || bus.out_id !== 2'd0) begin failures++; $display("FAIL bp_pop_cycle: got ready=%b id=%0d expected 0000/0", bus.req_ready, bus.out_id); end
        cyc();
        bus.out_ready = 1'b0; #1;
        checks++; if (bus.inflight !== 3'd3) begin failures++; $display("FAIL bp_after_pop: got %0d expected 3", bus.inflight); end
        checks++; if (bus.req_ready !== 4'b0001 || bus.out_id !== 2'd1) begin failures++; $display("FAIL bp_regrant: got ready=%b id=%0d expected 0001/1", bus.req_ready, bus.out_id); end
        cyc();
        bus.req_valid = '0; bus.out_ready = 1'b1;
        for (int d = 0; d < 4; d++) begin
            #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_id !== ids[d] || bus.out_data[15:0] !== 16'(int'(ids[d])*16)) begin failures++; $display("FAIL bp_drain[%0d]: got valid=%b id=%0d d=%h expected id=%0d", d, bus.out_valid, bus.out_id, bus.out_data[15:0], ids[d]); end
            cyc();
        end
        checks++; if (bus.inflight !== 3'd0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty: got inflight=%0d valid=%b expected 0/0", bus.inflight, bus.out_valid); end
    endtask

    task automatic test_reset_midflight;
        int nout;
        nout = 0;
        do_reset();
        bus.out_ready = 1'b0; bus.req_valid = '1; set_all(5);
        for (int t = 0; t < 4; t++) cyc();
        checks++; if (bus.inflight !== 3'd4) begin failures++; $display("FAIL mid_prefill: got %0d expected 4", bus.inflight); end
        rst_n = 1'b0; #1;
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL mid_ready_in_reset: got %b expected 0000", bus.req_ready); end
        cyc();
        rst_n = 1'b1; set_all(9); bus.out_ready = 1'b1; #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.inflight !== 3'd0 || bus.out_data !== '0) begin failures++; $display("FAIL mid_cleared: got valid=%b inflight=%0d expected 0/0", bus.out_valid, bus.inflight); end
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL mid_first_grant: got %b expected 0001", bus.req_ready); end
        for (int t = 0; t < 10; t++) begin
            bus.req_valid = (t < 4) ? 4'b1111 : 4'b0000;
            #1;
            if (bus.out_valid === 1'b1) begin
                checks++; if (nout >= 4 || bus.out_id !== ID_W'(nout) || bus.out_data[15:0] !== 16'(nout*16 + 9)) begin failures++; $display("FAIL mid_post_out[%0d]: got id=%0d d=%h expected id=%0d d=%h", nout, bus.out_id, bus.out_data[15:0], nout, 16'(nout*16 + 9)); end
                nout++;
            end
            cyc();
        end
        checks++; if (nout !== 4) begin failures++; $display("FAIL mid_post_count: got %0d expected 4", nout); end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_rr();
        test_back_to_back();
        test_sparse();
        test_backpressure();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
